// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the decode stage and the pipeline controller.
// master drives the DC/EX/WB request side, slave is the controller.
interface pipe_ctrl_if #(
    parameter int REG_IDX_WIDTH = 4,
    parameter int STAT_WIDTH    = 16
);
    localparam int NREG = 2**REG_IDX_WIDTH;

    logic                     in_dc_valid;
    logic [REG_IDX_WIDTH-1:0] in_dc_src1_idx;
    logic [REG_IDX_WIDTH-1:0] in_dc_src2_idx;
    logic                     in_dc_src1_used;
    logic                     in_dc_src2_used;
    logic [REG_IDX_WIDTH-1:0] in_dc_dst_idx;
    logic                     in_dc_dst_write;
    logic                     in_set_pc;
    logic                     in_wb_write;
    logic [REG_IDX_WIDTH-1:0] in_wb_idx;
    logic                     in_kill_valid;
    logic [REG_IDX_WIDTH-1:0] in_kill_idx;

    logic                     out_stall;
    logic                     out_issue;
    logic                     out_flush_FE;
    logic                     out_flush_pipeline;
    logic                     out_fwd_src1;
    logic                     out_fwd_src2;
    logic [NREG-1:0]          out_busy;
    logic [STAT_WIDTH-1:0]    out_stall_cnt;

    modport master (
        output in_dc_valid, in_dc_src1_idx, in_dc_src2_idx, in_dc_src1_used,
               in_dc_src2_used, in_dc_dst_idx, in_dc_dst_write, in_set_pc,
               in_wb_write, in_wb_idx, in_kill_valid, in_kill_idx,
        input  out_stall, out_issue, out_flush_FE, out_flush_pipeline,
               out_fwd_src1, out_fwd_src2, out_busy, out_stall_cnt
    );

    modport slave (
        input  in_dc_valid, in_dc_src1_idx, in_dc_src2_idx, in_dc_src1_used,
               in_dc_src2_used, in_dc_dst_idx, in_dc_dst_write, in_set_pc,
               in_wb_write, in_wb_idx, in_kill_valid, in_kill_idx,
        output out_stall, out_issue, out_flush_FE, out_flush_pipeline,
               out_fwd_src1, out_fwd_src2, out_busy, out_stall_cnt
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Scoreboard-based issue/stall/flush controller with per-register pending-write counters.
// Optional WB->DC operand forwarding is enabled by defining PIPE_CTRL_FWD_EN.
module pipe_ctrl #(
    parameter int REG_IDX_WIDTH = 4,
    parameter int MAX_INFLIGHT  = 3,
    parameter int FLUSH_CYCLES  = 2,
    parameter int STAT_WIDTH    = 16
) (
    input logic        clock,
    input logic        reset,
    pipe_ctrl_if.slave bus
);
    localparam int NREG = 2**REG_IDX_WIDTH;
    localparam int CW   = $clog2(MAX_INFLIGHT + 1);

    typedef enum logic {RUN, FLUSH} state_t;

    state_t                   state_q, state_d;
    logic [3:0]               flush_cnt_q, flush_cnt_d;
    logic [NREG-1:0][CW-1:0]  cnt_q, cnt_d;
    logic [STAT_WIDTH-1:0]    stall_cnt_q, stall_cnt_d;

    logic [NREG-1:0]          inc_v, dwb_v, dkl_v, underflow;
    logic [NREG-1:0][CW-1:0]  dec_v;
    logic                     fwd1, fwd2, hazard, accept, issue, stall;

`ifdef PIPE_CTRL_FWD_EN
    // A single outstanding writer retiring this cycle can feed its result straight to DC.
    assign fwd1 = bus.in_dc_src1_used && bus.in_wb_write &&
                  (bus.in_wb_idx == bus.in_dc_src1_idx) &&
                  (cnt_q[bus.in_dc_src1_idx] == CW'(1));
    assign fwd2 = bus.in_dc_src2_used && bus.in_wb_write &&
                  (bus.in_wb_idx == bus.in_dc_src2_idx) &&
                  (cnt_q[bus.in_dc_src2_idx] == CW'(1));
`else
    assign fwd1 = 1'b0;
    assign fwd2 = 1'b0;
`endif

    always_comb begin
        hazard = (bus.in_dc_src1_used && (cnt_q[bus.in_dc_src1_idx] != '0) && !fwd1) ||
                 (bus.in_dc_src2_used && (cnt_q[bus.in_dc_src2_idx] != '0) && !fwd2) ||
                 (bus.in_dc_dst_write && (cnt_q[bus.in_dc_dst_idx] == CW'(MAX_INFLIGHT)));
        accept = !reset && bus.in_dc_valid && (state_q == RUN) && !bus.in_set_pc;
        issue  = accept && !hazard;
        stall  = accept && hazard;
    end

    assign bus.out_issue          = issue;
    assign bus.out_stall          = stall;
    assign bus.out_flush_FE       = !reset && (bus.in_set_pc || (state_q == FLUSH));
    assign bus.out_flush_pipeline = !reset && (bus.in_set_pc || (state_q == FLUSH));
    assign bus.out_fwd_src1       = !reset && fwd1;
    assign bus.out_fwd_src2       = !reset && fwd2;
    assign bus.out_stall_cnt      = reset ? '0 : stall_cnt_q;

    always_comb begin
        bus.out_busy = '0;
        for (int r = 0; r < NREG; r++)
            bus.out_busy[r] = !reset && (cnt_q[r] != '0);
    end

    // A set_pc arriving mid-flush reloads the counter so the flush window restarts.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            RUN: begin
                if (bus.in_set_pc) begin
                    state_d     = FLUSH;
                    flush_cnt_d = 4'(FLUSH_CYCLES);
                end
            end
            FLUSH: begin
                if (bus.in_set_pc) begin
                    flush_cnt_d = 4'(FLUSH_CYCLES);
                end else if (flush_cnt_q == 4'd1) begin
                    state_d     = RUN;
                    flush_cnt_d = '0;
                end else begin
                    flush_cnt_d = flush_cnt_q - 4'd1;
                end
            end
            default: begin
                state_d     = RUN;
                flush_cnt_d = '0;
            end
        endcase
    end

    // Decrements are clamped to the current count; the excess is reported as underflow.
    always_comb begin
        cnt_d     = cnt_q;
        inc_v     = '0;
        dwb_v     = '0;
        dkl_v     = '0;
        dec_v     = '0;
        underflow = '0;
        for (int r = 0; r < NREG; r++) begin
            inc_v[r] = issue && bus.in_dc_dst_write && (bus.in_dc_dst_idx == REG_IDX_WIDTH'(r));
            dwb_v[r] = bus.in_wb_write && (bus.in_wb_idx == REG_IDX_WIDTH'(r));
            dkl_v[r] = bus.in_kill_valid && (bus.in_kill_idx == REG_IDX_WIDTH'(r));
            if (cnt_q[r] != '0) begin
                if (dwb_v[r] && dkl_v[r] && (cnt_q[r] != CW'(1)))
                    dec_v[r] = CW'(2);
                else if (dwb_v[r] || dkl_v[r])
                    dec_v[r] = CW'(1);
            end
            underflow[r] = ((cnt_q[r] == '0) && (dwb_v[r] || dkl_v[r])) ||
                           ((cnt_q[r] == CW'(1)) && dwb_v[r] && dkl_v[r]);
            cnt_d[r] = cnt_q[r] + CW'(inc_v[r]) - dec_v[r];
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + STAT_WIDTH'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= RUN;
            flush_cnt_q <= '0;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clock) begin
        if (!reset && (underflow != '0))
            $error("pipe_ctrl: writeback/kill to register with no pending write, mask %h", underflow);
    end
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomized and directed bench for pipe_ctrl against a behavioural scoreboard model.
module tb_pipe_ctrl;
    localparam int RW = 4;
    localparam int MI = 3;
    localparam int FC = 2;
    localparam int SW = 10;
    localparam int NR = 1 << RW;
`ifdef PIPE_CTRL_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    pipe_ctrl_if #(.REG_IDX_WIDTH(RW), .STAT_WIDTH(SW)) bus ();

    pipe_ctrl #(.REG_IDX_WIDTH(RW), .MAX_INFLIGHT(MI), .FLUSH_CYCLES(FC), .STAT_WIDTH(SW)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int errors = 0;
    int checks = 0;

    // Model: outstanding writes per register, remaining flush cycles, stall statistic.
    int m_cnt[NR];
    int m_flush;
    int m_stall;

    logic          s_issue, s_stall, s_ffe, s_fpl, s_fwd1, s_fwd2;
    logic [NR-1:0] s_busy;
    logic [SW-1:0] s_scnt;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_in();
        bus.in_dc_valid     = 1'b0;
        bus.in_dc_src1_idx  = '0;
        bus.in_dc_src2_idx  = '0;
        bus.in_dc_src1_used = 1'b0;
        bus.in_dc_src2_used = 1'b0;
        bus.in_dc_dst_idx   = '0;
        bus.in_dc_dst_write = 1'b0;
        bus.in_set_pc       = 1'b0;
        bus.in_wb_write     = 1'b0;
        bus.in_wb_idx       = '0;
        bus.in_kill_valid   = 1'b0;
        bus.in_kill_idx     = '0;
    endtask

    // One cycle: compare DUT outputs against the model mid-cycle, then advance the model.
    task automatic step();
        bit            fl, f1, f2, hz, e_iss, e_stl, e_fl;
        logic [NR-1:0] e_busy;
        int            e_scnt, dec, inc;
        #3;
        s_issue = bus.out_issue;
        s_stall = bus.out_stall;
        s_ffe   = bus.out_flush_FE;
        s_fpl   = bus.out_flush_pipeline;
        s_fwd1  = bus.out_fwd_src1;
        s_fwd2  = bus.out_fwd_src2;
        s_busy  = bus.out_busy;
        s_scnt  = bus.out_stall_cnt;
        e_busy  = '0;
        if (reset) begin
            {e_iss, e_stl, e_fl, f1, f2} = '0;
            e_scnt = 0;
        end else begin
            fl = (m_flush > 0);
            f1 = FWD && bus.in_dc_src1_used && bus.in_wb_write &&
                 bus.in_wb_idx == bus.in_dc_src1_idx && m_cnt[bus.in_dc_src1_idx] == 1;
            f2 = FWD && bus.in_dc_src2_used && bus.in_wb_write &&
                 bus.in_wb_idx == bus.in_dc_src2_idx && m_cnt[bus.in_dc_src2_idx] == 1;
            hz = (bus.in_dc_src1_used && m_cnt[bus.in_dc_src1_idx] != 0 && !f1) ||
                 (bus.in_dc_src2_used && m_cnt[bus.in_dc_src2_idx] != 0 && !f2) ||
                 (bus.in_dc_dst_write && m_cnt[bus.in_dc_dst_idx] == MI);
            e_iss = bus.in_dc_valid && !hz && !fl && !bus.in_set_pc;
            e_stl = bus.in_dc_valid &&  hz && !fl && !bus.in_set_pc;
            e_fl  = bus.in_set_pc || fl;
            for (int r = 0; r < NR; r++) e_busy[r] = (m_cnt[r] != 0);
            e_scnt = m_stall;
        end
        chk("issue", s_issue, e_iss);
        chk("stall", s_stall, e_stl);
        chk("flush_fe", s_ffe, e_fl);
        chk("flush_pl", s_fpl, e_fl);
        chk("fwd1", s_fwd1, f1);
        chk("fwd2", s_fwd2, f2);
        chk("busy", s_busy, e_busy);
        chk("stall_cnt", s_scnt, e_scnt);
        if (reset) begin
            for (int r = 0; r < NR; r++) m_cnt[r] = 0;
            m_flush = 0;
            m_stall = 0;
        end else begin
            if (e_stl && m_stall < (1 << SW) - 1) m_stall++;
            if (bus.in_set_pc) m_flush = FC;
            else if (m_flush > 0) m_flush--;
            for (int r = 0; r < NR; r++) begin
                inc = (e_iss && bus.in_dc_dst_write && bus.in_dc_dst_idx == r) ? 1 : 0;
                dec = ((bus.in_wb_write && bus.in_wb_idx == r) ? 1 : 0) +
                      ((bus.in_kill_valid && bus.in_kill_idx == r) ? 1 : 0);
                if (dec > m_cnt[r]) dec = m_cnt[r];
                m_cnt[r] = m_cnt[r] + inc - dec;
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic issue_dst(input int d);
        clear_in();
        bus.in_dc_valid     = 1'b1;
        bus.in_dc_dst_idx   = RW'(d);
        bus.in_dc_dst_write = 1'b1;
    endtask

    initial begin
        int r, k, rem;
        for (int i = 0; i < NR; i++) m_cnt[i] = 0;
        m_flush = 0;
        m_stall = 0;
        clear_in();
        reset = 1'b1;
        @(posedge clock);
        #1;
        step();
        step();
        reset = 1'b0;
        step();
        chk("idle_busy", s_busy, 0);
        chk("idle_scnt", s_scnt, 0);

        // First write to r3 issues and marks r3 busy.
        issue_dst(3);
        step();
        chk("r3_issue", s_issue, 1);
        clear_in();
        step();
        chk("r3_busy", s_busy[3], 1);
        chk("r3_model_cnt", m_cnt[3], 1);

        // Reader of r3 stalls until the writeback.
        clear_in();
        bus.in_dc_valid     = 1'b1;
        bus.in_dc_src1_idx  = 4'd3;
        bus.in_dc_src1_used = 1'b1;
        step();
        chk("raw_stall0", s_stall, 1);
        step();
        chk("raw_stall1", s_stall, 1);
        chk("raw_scnt1", s_scnt, 1);
        bus.in_wb_write = 1'b1;
        bus.in_wb_idx   = 4'd3;
        step();
        chk("raw_wb_issue", s_issue, FWD ? 1 : 0);
        chk("raw_wb_fwd1", s_fwd1, FWD ? 1 : 0);
        bus.in_wb_write = 1'b0;
        if (!FWD) begin
            step();
            chk("raw_late_issue", s_issue, 1);
        end
        clear_in();
        step();
        chk("raw_scnt_total", s_scnt, FWD ? 2 : 3);

        // Fill r5 to the in-flight limit.
        for (int i = 0; i < 3; i++) begin
            issue_dst(5);
            step();
            chk("r5_fill_issue", s_issue, 1);
        end
        step();
        chk("r5_full_stall", s_stall, 1);
        bus.in_wb_write = 1'b1;
        bus.in_wb_idx   = 4'd5;
        step();
        chk("r5_wb_cycle_stall", s_stall, 1);
        bus.in_wb_write = 1'b0;
        step();
        chk("r5_after_wb_issue", s_issue, 1);
        chk("r5_model_cnt", m_cnt[5], 3);
        clear_in();
        for (int i = 0; i < 3; i++) begin
            bus.in_wb_write = 1'b1;
            bus.in_wb_idx   = 4'd5;
            step();
        end
        clear_in();
        step();
        chk("r5_drained", s_busy[5], 0);

        // Flush pulse: three flush cycles, DC ignored, then issue resumes.
        issue_dst(2);
        bus.in_set_pc = 1'b1;
        step();
        chk("fl0_fe", s_ffe, 1);
        chk("fl0_issue", s_issue, 0);
        bus.in_set_pc = 1'b0;
        step();
        chk("fl1_pl", s_fpl, 1);
        chk("fl1_stall", s_stall, 0);
        step();
        chk("fl2_fe", s_ffe, 1);
        step();
        chk("fl3_fe", s_ffe, 0);
        chk("fl3_issue", s_issue, 1);
        clear_in();
        bus.in_set_pc = 1'b1;
        step();
        bus.in_set_pc = 1'b0;
        step();
        bus.in_set_pc = 1'b1;
        step();
        chk("re_fl_pulse", s_ffe, 1);
        bus.in_set_pc = 1'b0;
        step();
        chk("re_fl_a", s_ffe, 1);
        step();
        chk("re_fl_b", s_ffe, 1);
        step();
        chk("re_fl_done", s_ffe, 0);

        // Same-cycle issue and writeback on r7 cancel out; kill clears it.
        issue_dst(7);
        step();
        issue_dst(7);
        bus.in_wb_write = 1'b1;
        bus.in_wb_idx   = 4'd7;
        step();
        chk("r7_net_issue", s_issue, 1);
        clear_in();
        step();
        chk("r7_net_busy", s_busy[7], 1);
        chk("r7_model_cnt", m_cnt[7], 1);
        bus.in_kill_valid = 1'b1;
        bus.in_kill_idx   = 4'd7;
        step();
        clear_in();
        step();
        chk("r7_killed", s_busy[7], 0);

        // Randomized traffic; decrements only target registers with pending writes.
        for (int c = 0; c < 3000; c++) begin
            clear_in();
            reset                = ($urandom_range(0, 199) == 0);
            bus.in_dc_valid      = ($urandom_range(0, 3) != 0);
            bus.in_dc_src1_idx   = RW'($urandom_range(0, 7));
            bus.in_dc_src2_idx   = RW'($urandom_range(0, 7));
            bus.in_dc_src1_used  = 1'($urandom_range(0, 1));
            bus.in_dc_src2_used  = 1'($urandom_range(0, 1));
            bus.in_dc_dst_idx    = RW'($urandom_range(0, 7));
            bus.in_dc_dst_write  = ($urandom_range(0, 3) != 0);
            bus.in_set_pc        = ($urandom_range(0, 15) == 0);
            r = $urandom_range(0, 7);
            if (m_cnt[r] > 0 && $urandom_range(0, 1) == 1) begin
                bus.in_wb_write = 1'b1;
                bus.in_wb_idx   = RW'(r);
            end
            k = $urandom_range(0, 7);
            rem = m_cnt[k] - ((bus.in_wb_write && bus.in_wb_idx == k) ? 1 : 0);
            if (rem > 0 && $urandom_range(0, 3) == 0) begin
                bus.in_kill_valid = 1'b1;
                bus.in_kill_idx   = RW'(k);
            end
            step();
        end

        // Stall statistic saturation and reset clear.
        clear_in();
        reset = 1'b1;
        step();
        reset = 1'b0;
        issue_dst(9);
        step();
        clear_in();
        bus.in_dc_valid     = 1'b1;
        bus.in_dc_src1_idx  = 4'd9;
        bus.in_dc_src1_used = 1'b1;
        for (int i = 0; i < (1 << SW) + 5; i++) step();
        clear_in();
        step();
        chk("scnt_saturated", s_scnt, (1 << SW) - 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        chk("scnt_reset", s_scnt, 0);
        chk("busy_reset", s_busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
